// File: rtl/rv_mul_pkg.sv
// Shared constants, Booth digit type and elaboration helpers for the rv_mul multiplier.
// RV_MUL_OUT_REG_EN adds an output register stage (latency 3 instead of 2).
package rv_mul_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NUM_PP   = XLEN_DEF / 2 + 1;

`ifdef RV_MUL_OUT_REG_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
        logic zero;
    } booth_t;

    function automatic int num_pp(input int xlen);
        return xlen / 2 + 1;
    endfunction

    // Rows left after lvl levels of 3:2 compression; leftover rows pass straight through.
    function automatic int rows_after(input int n0, input int lvl);
        int n;
        n = n0;
        for (int i = 0; i < lvl; i++) n = n - n / 3;
        return n;
    endfunction

    function automatic int tree_levels(input int n0);
        int n;
        int l;
        n = n0;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

    // Triple is {y[2i+1], y[2i], y[2i-1]}.
    function automatic booth_t booth_enc(input logic [2:0] t);
        booth_t d;
        d.zero = (t == 3'b000) || (t == 3'b111);
        d.one  = t[1] ^ t[0];
        d.two  = (t == 3'b100) || (t == 3'b011);
        d.neg  = t[2] & ~(t[1] & t[0]);
        return d;
    endfunction

endpackage

// File: rtl/rv_mul_csa.sv
// One 3:2 carry-save compressor row; carry is pre-shifted to its weight and truncated.
module rv_mul_csa #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_maj;

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_carry = {w_maj[W-2:0], 1'b0};

endmodule

// File: rtl/rv_mul.sv
// Pipelined low-half multiplier: radix-4 Booth, Wallace CSA tree, registered final add.
// RV_MUL_OUT_REG_EN inserts one more flop between the adder and mul_result_o.
module rv_mul
    import rv_mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] mul_op1_i,
    input  logic [XLEN-1:0] mul_op2_i,
    output logic [XLEN-1:0] mul_result_o
);

    localparam int NPP   = num_pp(XLEN);
    localparam int NROW0 = NPP + 1;
    localparam int NLVL  = tree_levels(NROW0);

    logic [XLEN+2:0] w_ext;
    logic [XLEN-1:0] w_op1x2;
    booth_t          w_booth [NPP];
    logic [XLEN-1:0] w_pp    [NPP];
    logic [XLEN-1:0] w_negrow;
    logic [XLEN-1:0] w_tree  [NLVL+1][NROW0];
    logic [XLEN-1:0] w_add;
    logic [XLEN-1:0] r_sum, r_carry, r_res;

    // Implicit y[-1]=0 below, two copies of the sign on top for the last digit.
    assign w_ext   = {{2{mul_op2_i[XLEN-1]}}, mul_op2_i, 1'b0};
    assign w_op1x2 = {mul_op1_i[XLEN-2:0], 1'b0};

    // The +1 of each negated row lands on bit 2i; those never collide, so one row carries all.
    for (genvar i = 0; i < NPP; i++) begin : g_pp
        logic [XLEN-1:0] w_mag;
        assign w_booth[i] = booth_enc(w_ext[2*i+2 -: 3]);
        assign w_mag      = ({XLEN{w_booth[i].one}} & mul_op1_i) |
                            ({XLEN{w_booth[i].two}} & w_op1x2);
        assign w_pp[i]    = (w_mag ^ {XLEN{w_booth[i].neg & ~w_booth[i].zero}}) << (2*i);
        if (2*i < XLEN) begin : g_neg
            assign w_negrow[2*i]   = w_booth[i].neg;
            assign w_negrow[2*i+1] = 1'b0;
        end
    end

    for (genvar r = 0; r < NPP; r++) begin : g_row0
        assign w_tree[0][r] = w_pp[r];
    end
    assign w_tree[0][NPP] = w_negrow;

    for (genvar l = 0; l < NLVL; l++) begin : g_lvl
        localparam int N = rows_after(NROW0, l);
        localparam int G = N / 3;
        for (genvar g = 0; g < G; g++) begin : g_csa
            rv_mul_csa #(.W(XLEN)) u_csa (
                .i_a    (w_tree[l][3*g]),
                .i_b    (w_tree[l][3*g+1]),
                .i_c    (w_tree[l][3*g+2]),
                .o_sum  (w_tree[l+1][2*g]),
                .o_carry(w_tree[l+1][2*g+1])
            );
        end
        for (genvar p = 0; p < N - 3*G; p++) begin : g_pass
            assign w_tree[l+1][2*G+p] = w_tree[l][3*G+p];
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_res   <= '0;
        end else begin
            r_sum   <= w_tree[NLVL][0];
            r_carry <= w_tree[NLVL][1];
            r_res   <= w_add;
        end
    end

    assign w_add = r_sum + r_carry;

`ifdef RV_MUL_OUT_REG_EN
    logic [XLEN-1:0] r_out;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) r_out <= '0;
        else      r_out <= r_res;
    end

    assign mul_result_o = r_out;
`else
    assign mul_result_o = r_res;
`endif

endmodule

// File: tb/tb_rv_mul.sv
// Self-checking bench for rv_mul: reset, directed corners, Booth patterns, random stream.
module tb_rv_mul;

`ifdef RV_MUL_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rstn;
    logic [63:0] op1, op2;
    logic [63:0] res;

    int n_cmp;
    int n_err;
    logic [63:0] exp_q[$];

    rv_mul #(.XLEN(64)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mul_op1_i   (op1),
        .mul_op2_i   (op2),
        .mul_result_o(res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
        return a * b;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0:       v = 64'h8000_0000_0000_0000;
            1:       v = '1;
            2:       v = '0;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Apply a pair and hold it; result must appear LAT edges later and stay put.
    task automatic run_pair(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp);
        @(negedge clk);
        op1 = a;
        op2 = b;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k >= LAT) chk(tag, res, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b1;
        op1   = rnd64();
        op2   = rnd64();

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_hold", res, 64'd0);
            op1 = rnd64();
            op2 = rnd64();
        end

        // Release and apply the mixed-sign pair at the same negedge.
        @(negedge clk);
        rstn = 1'b0;
        op1  = 64'd11424;
        op2  = -64'sd22338;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (k < LAT) chk("mixed_early", res, 64'd0);
            else         chk("mixed_sign", res, 64'hFFFF_FFFF_F0CA_1EC0);
        end

        run_pair("max_pos_sq", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        run_pair("neg1_sq", '1, '1, 64'd1);
        run_pair("min_x_neg1", 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        run_pair("zero_op1", 64'd0, 64'h0000_0000_DEAD_BEEF, 64'd0);
        run_pair("booth_aa", 64'd3, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFE);
        run_pair("booth_55", 64'd3, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF);
        run_pair("booth_ff", 64'd3, '1, 64'hFFFF_FFFF_FFFF_FFFD);

        // Back-to-back stream: result of iteration j must show at iteration j+LAT.
        exp_q.delete();
        for (int i = 0; i < 1000 + LAT; i++) begin
            logic [63:0] a, b;
            @(negedge clk);
            if (i >= LAT) chk("stream", res, exp_q.pop_front());
            a = rnd64();
            b = rnd64();
            op1 = a;
            op2 = b;
            exp_q.push_back(model(a, b));
        end

        // Async reset in mid-cycle with a nonzero product in the pipe.
        run_pair("pre_async", 64'd12345, 64'd678, 64'd8369910);
        @(posedge clk);
        #2 rstn = 1'b1;
        #1 chk("async_rst", res, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_flush", res, 64'd0);
        end
        @(negedge clk);
        rstn = 1'b0;
        op1  = 64'hFFFF_FFFF_FFFF_FFF9;
        op2  = 64'd6;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k < LAT) chk("post_rst_early", res, 64'd0);
            else         chk("post_rst", res, 64'hFFFF_FFFF_FFFF_FFD6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
